// File: rtl/inst_axi_bridge_pkg.sv
// Shared constants and types for the instruction-side sram-to-AXI read bridge.
package inst_axi_bridge_pkg;

   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_BUSY = 1'b1
   } ar_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_axi_bridge_if.sv
// Bus bundles for the bridge: IF-side sram-like fetch port and AXI4 read (AR/R) channels.
interface inst_sram_if;
   logic        inst_sram_req;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   modport master (
      output inst_sram_req, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
   );
   modport slave (
      input  inst_sram_req, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
   );
endinterface

interface axi_rd_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [1:0]  rresp;
   logic        rlast;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
      input  arready, rid, rresp, rlast, rdata, rvalid
   );
   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
      output arready, rid, rresp, rlast, rdata, rvalid
   );
endinterface

// File: rtl/inst_axi_bridge_rbuf.sv
// One-entry R capture register: re-times data_ok/rdata one cycle after the R beat.
module inst_axi_rbuf (
   input  logic        clk,
   input  logic        resetn,
   input  logic        beat,
   input  logic [31:0] beat_data,
   output logic        data_ok,
   output logic [31:0] rdata
);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         data_ok <= 1'b0;
         rdata   <= '0;
      end else begin
         data_ok <= beat;
         if (beat) rdata <= beat_data;
      end
   end

endmodule

// File: rtl/inst_axi_bridge.sv
// Instruction fetch bridge: sram-like requests -> single-beat AXI4 reads, data returned in order.
// Define INST_AXI_RBUF_EN to register the R beat before data_ok (+1 cycle latency).
module inst_axi_bridge
   import inst_axi_bridge_pkg::*;
#(
   parameter int unsigned MAX_OUTST = 2,
   parameter logic [3:0]  ARID_VAL  = 4'h0
) (
   input  logic      clk,
   input  logic      resetn,
   inst_sram_if.slave sram,
   axi_rd_if.master   axi
);

   localparam int unsigned CW = $clog2(MAX_OUTST + 1);

   ar_state_t     ar_state, ar_state_nxt;
   logic [31:0]   araddr_q;
   logic [CW-1:0] outst_cnt;
   logic          rready_q;
   logic          ar_busy, slot_free, addr_ok, accept;
   logic          ar_fire, r_fire, r_done;
   logic [31:0]   occupancy;
   logic          data_ok;
   logic [31:0]   rdata_out;
   logic          unused_ok;

   assign ar_busy   = (ar_state == AR_BUSY);
   assign occupancy = 32'(outst_cnt) + 32'(ar_busy);
   assign slot_free = !ar_busy && (occupancy < MAX_OUTST);
   assign addr_ok   = sram.inst_sram_req && slot_free;
   assign accept    = addr_ok;

   assign ar_fire = ar_busy && axi.arready;
   assign r_fire  = axi.rvalid && rready_q;
   // a stray beat with nothing outstanding must not wrap the counter
   assign r_done  = r_fire && axi.rlast && (outst_cnt != '0);

   always_comb begin
      ar_state_nxt = ar_state;
      case (ar_state)
         AR_IDLE: if (accept)      ar_state_nxt = AR_BUSY;
         AR_BUSY: if (axi.arready) ar_state_nxt = AR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) ar_state <= AR_IDLE;
      else         ar_state <= ar_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!resetn)     araddr_q <= '0;
      else if (accept) araddr_q <= word_align(sram.inst_sram_addr);
   end

   always_ff @(posedge clk) begin
      if (!resetn)                outst_cnt <= '0;
      else if (ar_fire && !r_done) outst_cnt <= outst_cnt + CW'(1);
      else if (!ar_fire && r_done) outst_cnt <= outst_cnt - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) rready_q <= 1'b0;
      else         rready_q <= 1'b1;
   end

   r_beat_has_owner: assert property (@(posedge clk) disable iff (!resetn)
      r_fire |-> (outst_cnt != '0));

`ifdef INST_AXI_RBUF_EN
   inst_axi_rbuf u_rbuf (
      .clk       (clk),
      .resetn    (resetn),
      .beat      (r_fire),
      .beat_data (axi.rdata),
      .data_ok   (data_ok),
      .rdata     (rdata_out)
   );
`else
   assign data_ok   = r_fire;
   assign rdata_out = r_fire ? axi.rdata : '0;
`endif

   assign sram.inst_sram_addr_ok = addr_ok;
   assign sram.inst_sram_data_ok = data_ok;
   assign sram.inst_sram_rdata   = rdata_out;

   assign axi.arid    = ARID_VAL;
   assign axi.araddr  = araddr_q;
   assign axi.arlen   = AXI_LEN_SINGLE;
   assign axi.arsize  = AXI_SIZE_WORD;
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.arlock  = '0;
   assign axi.arcache = '0;
   assign axi.arprot  = '0;
   assign axi.arvalid = ar_busy;
   assign axi.rready  = rready_q;

   assign unused_ok = ^{sram.inst_sram_wen, sram.inst_sram_wdata, sram.inst_sram_addr[1:0],
                        axi.rid, axi.rresp};

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Self-checking bench for inst_axi_bridge: scoreboard of expected AR addresses and fetch data.
module tb_inst_axi_bridge;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   inst_sram_if sram();
   axi_rd_if    axi();

   inst_axi_bridge #(.MAX_OUTST(2), .ARID_VAL(4'h5)) dut (
      .clk    (clk),
      .resetn (resetn),
      .sram   (sram),
      .axi    (axi)
   );

`ifdef INST_AXI_RBUF_EN
   localparam logic [1:0] LAT_PATTERN = 2'b01;
`else
   localparam logic [1:0] LAT_PATTERN = 2'b10;
`endif

   int tests = 0;
   int fails = 0;
   int data_ok_cnt = 0;
   logic [31:0] exp_araddr_q[$];
   logic [31:0] exp_rdata_q[$];
   logic [31:0] slave_q[$];
   logic [31:0] last_rdata, last_araddr, mon_e;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h83dd0000;
   endfunction

   // scoreboard: push on accept, pop on AR handshake and on data_ok
   always @(negedge clk) begin
      if (resetn) begin
         if (sram.inst_sram_req && sram.inst_sram_addr_ok) begin
            exp_araddr_q.push_back({sram.inst_sram_addr[31:2], 2'b00});
            exp_rdata_q.push_back(mem_word(sram.inst_sram_addr));
         end
         if (axi.arvalid && axi.arready) begin
            tests++;
            if (exp_araddr_q.size() == 0) begin
               fails++;
               $display("FAIL ar_unexpected: araddr=%h, required no AR", axi.araddr);
            end else begin
               mon_e = exp_araddr_q.pop_front();
               if (axi.araddr !== mon_e) begin
                  fails++;
                  $display("FAIL ar_addr: araddr=%h, required %h", axi.araddr, mon_e);
               end
            end
            tests++;
            if ({axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot}
                !== {4'h5, 8'd0, 3'd2, 2'b01, 2'b00, 4'h0, 3'h0}) begin
               fails++;
               $display("FAIL ar_fields: id=%h len=%h size=%h burst=%h lock=%h cache=%h prot=%h, required 5/00/2/1/0/0/0",
                        axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot);
            end
            last_araddr = axi.araddr;
            slave_q.push_back(axi.araddr);
         end
         if (sram.inst_sram_data_ok) begin
            tests++;
            if (exp_rdata_q.size() == 0) begin
               fails++;
               $display("FAIL data_unexpected: rdata=%h, required no data_ok", sram.inst_sram_rdata);
            end else begin
               mon_e = exp_rdata_q.pop_front();
               if (sram.inst_sram_rdata !== mon_e) begin
                  fails++;
                  $display("FAIL data_value: rdata=%h, required %h", sram.inst_sram_rdata, mon_e);
               end
            end
            data_ok_cnt++;
            last_rdata = sram.inst_sram_rdata;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a);
      bit ok;
      ok = 1'b0;
      sram.inst_sram_req  = 1'b1;
      sram.inst_sram_addr = a;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (sram.inst_sram_addr_ok) ok = 1'b1;
         tick();
      end
      sram.inst_sram_req = 1'b0;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL issue_timeout: addr=%h addr_ok=0, required accept within 40 cycles", a);
      end
   endtask

   task automatic wait_ar(input int n);
      for (int i = 0; i < 40 && slave_q.size() < n; i++) tick();
      tests++;
      if (slave_q.size() < n) begin
         fails++;
         $display("FAIL ar_timeout: %0d ARs seen, required %0d", slave_q.size(), n);
      end
   endtask

   task automatic r_beat();
      logic [31:0] a;
      wait_ar(1);
      if (slave_q.size() != 0) begin
         a = slave_q.pop_front();
         axi.rvalid = 1'b1;
         axi.rdata  = mem_word(a);
         axi.rlast  = 1'b1;
         tick();
         axi.rvalid = 1'b0;
         axi.rdata  = $urandom;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_rdata_q.size() != 0; i++) tick();
      tests++;
      if (exp_rdata_q.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout: %0d fetches unreturned, required 0", exp_rdata_q.size());
      end
   endtask

   task automatic clear_queues();
      exp_araddr_q.delete();
      exp_rdata_q.delete();
      slave_q.delete();
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      @(negedge clk);
      tests++;
      if ({axi.arvalid, axi.rready, sram.inst_sram_data_ok} !== 3'b000) begin
         fails++;
         $display("FAIL reset_ctrl: arvalid/rready/data_ok=%b, required 000",
                  {axi.arvalid, axi.rready, sram.inst_sram_data_ok});
      end
      tests++;
      if (sram.inst_sram_rdata !== 32'h0) begin
         fails++;
         $display("FAIL reset_rdata: rdata=%h, required 00000000", sram.inst_sram_rdata);
      end
      tick();
      resetn = 1'b1;
      tick();
      @(negedge clk);
      tests++;
      if ({axi.arvalid, axi.rready, sram.inst_sram_data_ok} !== 3'b010) begin
         fails++;
         $display("FAIL reset_release: arvalid/rready/data_ok=%b, required 010",
                  {axi.arvalid, axi.rready, sram.inst_sram_data_ok});
      end
      tick();
   endtask

   task automatic test_single();
      logic [31:0] a;
      logic [1:0]  seen;
      int base;
      base = data_ok_cnt;
      issue(32'hbfc00000);
      @(negedge clk);
      tests++;
      if (axi.arvalid !== 1'b1) begin
         fails++;
         $display("FAIL single_arvalid: arvalid=%b the cycle after accept, required 1", axi.arvalid);
      end
      tick();
      wait_ar(1);
      a = slave_q.pop_front();
      axi.rvalid = 1'b1;
      axi.rdata  = mem_word(a);
      @(negedge clk);
      seen[1] = sram.inst_sram_data_ok;
      tick();
      axi.rvalid = 1'b0;
      axi.rdata  = $urandom;
      @(negedge clk);
      seen[0] = sram.inst_sram_data_ok;
      tick();
      tests++;
      if (seen !== LAT_PATTERN) begin
         fails++;
         $display("FAIL single_latency: data_ok in beat/next cycle=%b, required %b", seen, LAT_PATTERN);
      end
      drain();
      tests++;
      if (data_ok_cnt - base !== 1) begin
         fails++;
         $display("FAIL single_pulses: %0d data_ok pulses, required 1", data_ok_cnt - base);
      end
      tests++;
      if (last_rdata !== 32'h3c1d0000 || last_araddr !== 32'hbfc00000) begin
         fails++;
         $display("FAIL single_values: rdata=%h araddr=%h, required 3c1d0000 bfc00000", last_rdata, last_araddr);
      end
   endtask

   task automatic test_ar_stall();
      axi.arready = 1'b0;
      issue(32'hbfc00100);
      sram.inst_sram_req  = 1'b1;
      sram.inst_sram_addr = 32'hbfc00200;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if ({axi.arvalid, sram.inst_sram_addr_ok} !== 2'b10 || axi.araddr !== 32'hbfc00100) begin
            fails++;
            $display("FAIL ar_stall: cycle %0d arvalid/addr_ok=%b araddr=%h, required 10 bfc00100",
                     i, {axi.arvalid, sram.inst_sram_addr_ok}, axi.araddr);
         end
         tick();
      end
      axi.arready = 1'b1;
      issue(32'hbfc00200);
      r_beat();
      r_beat();
      drain();
   endtask

   task automatic test_full();
      logic [31:0] a;
      issue(32'hbfc01000);
      issue(32'hbfc01004);
      sram.inst_sram_req  = 1'b1;
      sram.inst_sram_addr = 32'hbfc01008;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (sram.inst_sram_addr_ok !== 1'b0) begin
            fails++;
            $display("FAIL full_block: cycle %0d addr_ok=%b, required 0", i, sram.inst_sram_addr_ok);
         end
         tick();
      end
      wait_ar(2);
      a = slave_q.pop_front();
      axi.rvalid = 1'b1;
      axi.rdata  = mem_word(a);
      @(negedge clk);
      tests++;
      if (sram.inst_sram_addr_ok !== 1'b0) begin
         fails++;
         $display("FAIL full_during_beat: addr_ok=%b, required 0", sram.inst_sram_addr_ok);
      end
      tick();
      axi.rvalid = 1'b0;
      @(negedge clk);
      tests++;
      if (sram.inst_sram_addr_ok !== 1'b1) begin
         fails++;
         $display("FAIL full_release: addr_ok=%b after R beat, required 1", sram.inst_sram_addr_ok);
      end
      tick();
      sram.inst_sram_req = 1'b0;
      r_beat();
      r_beat();
      drain();
   endtask

   task automatic test_same_cycle();
      logic [31:0] a;
      issue(32'hbfc02000);
      wait_ar(1);
      axi.arready = 1'b0;
      issue(32'hbfc02004);
      tick();
      a = slave_q.pop_front();
      axi.arready = 1'b1;
      axi.rvalid  = 1'b1;
      axi.rdata   = mem_word(a);
      tick();
      axi.rvalid = 1'b0;
      sram.inst_sram_req  = 1'b1;
      sram.inst_sram_addr = 32'hbfc02008;
      @(negedge clk);
      tests++;
      if (sram.inst_sram_addr_ok !== 1'b1) begin
         fails++;
         $display("FAIL same_cycle_slot: addr_ok=%b with one outstanding, required 1", sram.inst_sram_addr_ok);
      end
      tick();
      sram.inst_sram_req = 1'b0;
      tick();
      sram.inst_sram_req  = 1'b1;
      sram.inst_sram_addr = 32'hbfc0200c;
      @(negedge clk);
      tests++;
      if (sram.inst_sram_addr_ok !== 1'b0) begin
         fails++;
         $display("FAIL same_cycle_full: addr_ok=%b with two outstanding, required 0", sram.inst_sram_addr_ok);
      end
      tick();
      sram.inst_sram_req = 1'b0;
      r_beat();
      r_beat();
      drain();
   endtask

   task automatic test_unaligned();
      issue(32'hbfc00002);
      r_beat();
      drain();
      tests++;
      if (last_araddr !== 32'hbfc00000 || last_rdata !== 32'h3c1d0000) begin
         fails++;
         $display("FAIL unaligned: araddr=%h rdata=%h, required bfc00000 3c1d0000", last_araddr, last_rdata);
      end
   endtask

   task automatic test_reset_mid();
      issue(32'hbfc03000);
      wait_ar(1);
      axi.arready = 1'b0;
      issue(32'hbfc03004);
      resetn = 1'b0;
      tick();
      clear_queues();
      @(negedge clk);
      tests++;
      if ({axi.arvalid, axi.rready, sram.inst_sram_data_ok} !== 3'b000 || sram.inst_sram_rdata !== 32'h0) begin
         fails++;
         $display("FAIL reset_mid: arvalid/rready/data_ok=%b rdata=%h, required 000 00000000",
                  {axi.arvalid, axi.rready, sram.inst_sram_data_ok}, sram.inst_sram_rdata);
      end
      tick();
      resetn = 1'b1;
      axi.arready = 1'b1;
      tick();
      issue(32'hbfc00000);
      issue(32'hbfc00004);
      r_beat();
      r_beat();
      drain();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, a2;
      int base;
      base = data_ok_cnt;
      for (int k = 0; k < 4; k++) begin
         a1 = $urandom;
         a2 = $urandom;
         issue(a1);
         issue(a2);
         r_beat();
         r_beat();
      end
      drain();
      tests++;
      if (data_ok_cnt - base !== 8) begin
         fails++;
         $display("FAIL b2b_count: %0d data_ok pulses, required 8", data_ok_cnt - base);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      resetn               = 1'b0;
      sram.inst_sram_req   = 1'b0;
      sram.inst_sram_wen   = 4'h0;
      sram.inst_sram_addr  = '0;
      sram.inst_sram_wdata = '0;
      axi.arready = 1'b1;
      axi.rvalid  = 1'b0;
      axi.rdata   = '0;
      axi.rid     = '0;
      axi.rresp   = '0;
      axi.rlast   = 1'b1;
      last_rdata  = '0;
      last_araddr = '0;
      test_reset();
      test_single();
      test_ar_stall();
      test_full();
      test_same_cycle();
      test_unaligned();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
